// File: rtl/cp0_int_ctrl.sv
// CP0 timer and interrupt controller: Count/Compare timer (IP7), Cause.IP merge
// with hardware/software sources, and a single-outstanding interrupt handshake FSM.
module cp0_int_ctrl #(
    parameter int unsigned CNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic [4:0]  hw_int,
    input  logic        status_ie,
    input  logic        status_exl,
    input  logic [7:0]  status_im,
    output logic        int_req,
    output logic [7:0]  int_code,
    input  logic        int_ack,
    input  logic        eret,
    output logic        timer_int
);

    localparam int unsigned PW = (CNT_DIV > 1) ? $clog2(CNT_DIV) : 1;

    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;
    localparam logic [4:0] ADDR_CAUSE   = 5'd13;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   count_q, count_d;
    logic [31:0]   compare_q, compare_d;
    logic [7:0]    ip_q, ip_d;
    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [7:0]    code_q, code_d;

    logic       wr_count, wr_compare, wr_cause;
    logic       tick;
    logic [7:0] pend;
    logic       qualify;

    assign wr_count   = we && (addr == ADDR_COUNT);
    assign wr_compare = we && (addr == ADDR_COMPARE);
    assign wr_cause   = we && (addr == ADDR_CAUSE);
    assign tick       = (presc_q == PW'(CNT_DIV - 1));

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        presc_d = presc_q;
        count_d = count_q;
        if (wr_count) begin
            count_d = wdata;
            presc_d = '0;
        end else if (tick) begin
            count_d = count_q + 32'd1;
            presc_d = '0;
        end else begin
            presc_d = presc_q + PW'(1);
        end
    end

    // A Compare write in the match cycle wins, so the timer bit is cleared, not set.
    always_comb begin
        compare_d = compare_q;
        ip_d      = ip_q;
        if (wr_compare) begin
            compare_d = wdata;
            ip_d[7]   = 1'b0;
        end else if (count_q == compare_q) begin
            ip_d[7]   = 1'b1;
        end
        ip_d[6:2] = hw_int;
        if (wr_cause) begin
            ip_d[1:0] = wdata[9:8];
        end
    end

    assign pend    = ip_q & status_im;
    assign qualify = (|pend) & status_ie & ~status_exl;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        code_d  = code_q;
        unique case (state_q)
            IDLE: begin
                if (qualify) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    code_d  = pend;
                end
            end
            REQ: begin
                if (int_ack) begin
                    state_d = SERVICE;
                    req_d   = 1'b0;
                end else if (!qualify) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end else begin
                    code_d  = pend;
                end
            end
            SERVICE: begin
                req_d = 1'b0;
                if (eret) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q   <= '0;
            count_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            ip_q      <= '0;
            state_q   <= IDLE;
            req_q     <= 1'b0;
            code_q    <= '0;
        end else begin
            presc_q   <= presc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            ip_q      <= ip_d;
            state_q   <= state_d;
            req_q     <= req_d;
            code_q    <= code_d;
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr)
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
            ADDR_CAUSE:   rdata = {16'b0, ip_q, 8'b0};
            default:      rdata = '0;
        endcase
    end

    assign int_req   = req_q;
    assign int_code  = code_q;
    assign timer_int = ip_q[7];

endmodule

// File: tb/tb_cp0_int_ctrl.sv
// Directed bench for cp0_int_ctrl: timer match/wrap, hardware and software
// interrupt paths, handshake ordering and asynchronous reset.
module tb_cp0_int_ctrl;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  hw_int;
    logic        status_ie;
    logic        status_exl;
    logic [7:0]  status_im;
    logic        int_req;
    logic [7:0]  int_code;
    logic        int_ack;
    logic        eret;
    logic        timer_int;

    int checks = 0;
    int errors = 0;

    cp0_int_ctrl #(.CNT_DIV(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .hw_int     (hw_int),
        .status_ie  (status_ie),
        .status_exl (status_exl),
        .status_im  (status_im),
        .int_req    (int_req),
        .int_code   (int_code),
        .int_ack    (int_ack),
        .eret       (eret),
        .timer_int  (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cp0_write(input logic [4:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        @(negedge clk);
        we    = 1'b0;
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    task automatic pulse_ack();
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        eret = 1'b1;
        @(negedge clk);
        eret = 1'b0;
    endtask

    initial begin
        int n;
        rst        = 1'b1;
        we         = 1'b0;
        addr       = 5'd0;
        wdata      = '0;
        hw_int     = '0;
        status_ie  = 1'b1;
        status_exl = 1'b0;
        status_im  = 8'h80;
        int_ack    = 1'b0;
        eret       = 1'b0;

        // Reset state
        #2;
        chk("rst_int_req", {31'b0, int_req}, 32'd0);
        chk("rst_int_code", {24'b0, int_code}, 32'd0);
        chk("rst_timer_int", {31'b0, timer_int}, 32'd0);
        read_chk("rst_count", 5'd9, 32'd0);
        read_chk("rst_compare", 5'd11, 32'hFFFF_FFFF);
        @(negedge clk);
        rst = 1'b0;

        // Timer interrupt: Compare=10, Count=0, CNT_DIV=2
        cp0_write(5'd11, 32'd10);
        read_chk("compare_rd", 5'd11, 32'd10);
        cp0_write(5'd9, 32'd0);
        n = 0;
        while (timer_int !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("timer_latency", n, 32'd21);
        chk("timer_req_not_yet", {31'b0, int_req}, 32'd0);
        @(negedge clk);
        chk("timer_req", {31'b0, int_req}, 32'd1);
        chk("timer_code", {24'b0, int_code}, 32'h80);
        read_chk("count_after_match", 5'd9, 32'd11);

        // Acknowledge, clear timer via Compare, return
        pulse_ack();
        chk("ack_req_low", {31'b0, int_req}, 32'd0);
        cp0_write(5'd11, 32'h100);
        chk("compare_clears_ip7", {31'b0, timer_int}, 32'd0);
        chk("service_req_low", {31'b0, int_req}, 32'd0);
        pulse_eret();
        @(negedge clk);
        chk("eret_no_new_req", {31'b0, int_req}, 32'd0);
        pulse_ack();
        chk("ack_idle_ignored", {31'b0, int_req}, 32'd0);

        // Hardware interrupt hw_int[2] -> IP4
        status_im = 8'h10;
        hw_int    = 5'b00100;
        @(negedge clk);
        chk("hw_req_not_yet", {31'b0, int_req}, 32'd0);
        @(negedge clk);
        chk("hw_req", {31'b0, int_req}, 32'd1);
        chk("hw_code", {24'b0, int_code}, 32'h10);
        read_chk("hw_cause_rd", 5'd13, 32'h0000_1000);
        hw_int = '0;
        @(negedge clk);
        chk("hw_req_held", {31'b0, int_req}, 32'd1);
        @(negedge clk);
        chk("hw_req_withdrawn", {31'b0, int_req}, 32'd0);

        // Compare write in the match cycle wins
        status_im = 8'h80;
        cp0_write(5'd11, 32'h50);
        cp0_write(5'd9, 32'h50);
        cp0_write(5'd11, 32'h200);
        chk("cmp_wr_wins", {31'b0, timer_int}, 32'd0);
        @(negedge clk);
        read_chk("count_0x51", 5'd9, 32'h51);
        @(negedge clk);
        chk("cmp_wr_wins_later", {31'b0, timer_int}, 32'd0);
        chk("cmp_wr_no_req", {31'b0, int_req}, 32'd0);

        // Count wrap to 0 matches Compare=0
        cp0_write(5'd11, 32'd0);
        cp0_write(5'd9, 32'hFFFF_FFFF);
        read_chk("count_max", 5'd9, 32'hFFFF_FFFF);
        chk("wrap_t0", {31'b0, timer_int}, 32'd0);
        @(negedge clk);
        chk("wrap_t1", {31'b0, timer_int}, 32'd0);
        @(negedge clk);
        read_chk("count_wrapped", 5'd9, 32'd0);
        chk("wrap_t2", {31'b0, timer_int}, 32'd0);
        @(negedge clk);
        chk("wrap_match", {31'b0, timer_int}, 32'd1);
        chk("wrap_req_not_yet", {31'b0, int_req}, 32'd0);
        @(negedge clk);
        chk("wrap_req", {31'b0, int_req}, 32'd1);
        chk("wrap_code", {24'b0, int_code}, 32'h80);
        pulse_ack();
        cp0_write(5'd11, 32'hFFFF_0000);
        pulse_eret();
        @(negedge clk);
        chk("wrap_cleanup_idle", {31'b0, int_req}, 32'd0);

        // Software interrupts gated by EXL
        status_exl = 1'b1;
        status_im  = 8'h03;
        cp0_write(5'd13, 32'h300);
        @(negedge clk);
        chk("sw_exl_blocks", {31'b0, int_req}, 32'd0);
        read_chk("sw_cause_rd", 5'd13, 32'h0000_0300);
        status_exl = 1'b0;
        @(negedge clk);
        chk("sw_req", {31'b0, int_req}, 32'd1);
        chk("sw_code", {24'b0, int_code}, 32'h03);
        pulse_eret();
        chk("eret_req_ignored", {31'b0, int_req}, 32'd1);
        status_im = 8'h01;
        @(negedge clk);
        chk("sw_code_refresh", {24'b0, int_code}, 32'h01);
        chk("sw_req_held", {31'b0, int_req}, 32'd1);
        pulse_ack();
        chk("sw_ack", {31'b0, int_req}, 32'd0);

        // Asynchronous reset during SERVICE
        #2;
        rst = 1'b1;
        #1;
        chk("arst_int_req", {31'b0, int_req}, 32'd0);
        chk("arst_int_code", {24'b0, int_code}, 32'd0);
        chk("arst_timer_int", {31'b0, timer_int}, 32'd0);
        read_chk("arst_compare", 5'd11, 32'hFFFF_FFFF);
        read_chk("arst_cause", 5'd13, 32'd0);
        read_chk("arst_count", 5'd9, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", {31'b0, int_req}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
